// File: rtl/adma_dm_axi_ar.sv
// Read-address issue stage of the DMA data mover: splits one source-read command into
// 4KB-safe AXI INCR bursts and mirrors each burst's record to the R-channel handler.
module adma_dm_axi_ar #(
    parameter int unsigned DMA_CHN_NUM    = 4,
    parameter int unsigned MST_ID_W       = 5,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned ATX_LEN_W      = 8,
    parameter int unsigned ATX_SIZE_W     = 3,
    parameter int unsigned ATX_SRC_DATA_W = 256,
    parameter int unsigned ATX_MAX_BEATS  = 256,
    parameter int unsigned CMD_BEATS_W    = 16,
    localparam int unsigned DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DMA_CHN_NUM_W-1:0] cmd_chn_id,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [CMD_BEATS_W-1:0]   cmd_beats,
    input  logic                     cmd_vld,
    output logic                     cmd_rdy,
    output logic                     cmd_done,
    input  logic [MST_ID_W-1:0]      atx_id [0:DMA_CHN_NUM-1],
    output logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
    output logic [MST_ID_W-1:0]      atx_arid,
    output logic [ATX_LEN_W-1:0]     atx_arlen,
    output logic                     atx_vld,
    input  logic                     atx_rdy,
    output logic [MST_ID_W-1:0]      m_arid_o,
    output logic [ADDR_W-1:0]        m_araddr_o,
    output logic [ATX_LEN_W-1:0]     m_arlen_o,
    output logic [ATX_SIZE_W-1:0]    m_arsize_o,
    output logic [1:0]               m_arburst_o,
    output logic                     m_arvalid_o,
    input  logic                     m_arready_i
);

    localparam int unsigned BEAT_BYTES = ATX_SRC_DATA_W / 8;
    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
    // Comparison width wide enough for rem_beats, the burst cap and the 4KB beat count.
    localparam int unsigned CW0 = (CMD_BEATS_W + 1 > 13) ? CMD_BEATS_W + 1 : 13;
    localparam int unsigned CW  = (CW0 > ATX_LEN_W + 1) ? CW0 : ATX_LEN_W + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BEAT_BYTES - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StIssue} state_e;

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        cur_addr_q, cur_addr_d;
    logic [CMD_BEATS_W-1:0]   rem_beats_q, rem_beats_d;
    logic [DMA_CHN_NUM_W-1:0] chn_q, chn_d;
    logic [ATX_LEN_W-1:0]     burst_len_q, burst_len_d;
    logic                     ar_done_q, ar_done_d;
    logic                     atx_done_q, atx_done_d;

    logic [12:0]            off_4k;
    logic [CW-1:0]          b4k, rem_ext, max_ext, beats;
    logic [ATX_LEN_W:0]     burst_beats;
    logic [CMD_BEATS_W-1:0] rem_next;
    logic                   ar_fin, atx_fin;

    // On an exact 4KB boundary the offset is 0, so this yields a full page.
    assign off_4k      = 13'h1000 - {1'b0, cur_addr_q[11:0]};
    assign b4k         = CW'(off_4k >> BEAT_SHIFT);
    assign rem_ext     = CW'(rem_beats_q);
    assign max_ext     = CW'(ATX_MAX_BEATS);
    assign burst_beats = {1'b0, burst_len_q} + (ATX_LEN_W + 1)'(1);
    assign rem_next    = rem_beats_q - CMD_BEATS_W'(burst_beats);

    always_comb begin
        beats = rem_ext;
        if (max_ext < beats) beats = max_ext;
        if (b4k < beats) beats = b4k;
    end

    assign m_arsize_o  = ATX_SIZE_W'(BEAT_SHIFT);
    assign m_arburst_o = 2'b01;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            rem_beats_q <= '0;
            chn_q       <= '0;
            burst_len_q <= '0;
            ar_done_q   <= 1'b0;
            atx_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_beats_q <= rem_beats_d;
            chn_q       <= chn_d;
            burst_len_q <= burst_len_d;
            ar_done_q   <= ar_done_d;
            atx_done_q  <= atx_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rem_beats_d = rem_beats_q;
        chn_d       = chn_q;
        burst_len_d = burst_len_q;
        ar_done_d   = ar_done_q;
        atx_done_d  = atx_done_q;
        cmd_rdy     = 1'b0;
        cmd_done    = 1'b0;
        atx_vld     = 1'b0;
        m_arvalid_o = 1'b0;
        atx_chn_id  = '0;
        atx_arid    = '0;
        atx_arlen   = '0;
        m_arid_o    = '0;
        m_araddr_o  = '0;
        m_arlen_o   = '0;
        ar_fin      = 1'b0;
        atx_fin     = 1'b0;

        case (state_q)
            StIdle: begin
                cmd_rdy = 1'b1;
                if (cmd_vld) begin
                    chn_d       = cmd_chn_id;
                    cur_addr_d  = cmd_addr & ALIGN_MASK;
                    rem_beats_d = cmd_beats;
                    state_d     = StCalc;
                end
            end
            StCalc: begin
                burst_len_d = ATX_LEN_W'(beats - CW'(1));
                ar_done_d   = 1'b0;
                atx_done_d  = 1'b0;
                state_d     = StIssue;
            end
            StIssue: begin
                m_arvalid_o = ~ar_done_q;
                atx_vld     = ~atx_done_q;
                m_arid_o    = atx_id[chn_q];
                m_araddr_o  = cur_addr_q;
                m_arlen_o   = burst_len_q;
                atx_chn_id  = chn_q;
                atx_arid    = atx_id[chn_q];
                atx_arlen   = burst_len_q;
                ar_fin      = ar_done_q | m_arready_i;
                atx_fin     = atx_done_q | atx_rdy;
                ar_done_d   = ar_fin;
                atx_done_d  = atx_fin;
                // Advance only once both the AR and the record side have handshaken.
                if (ar_fin && atx_fin) begin
                    cur_addr_d  = cur_addr_q + (ADDR_W'(burst_beats) << BEAT_SHIFT);
                    rem_beats_d = rem_next;
                    if (rem_next == '0) begin
                        cmd_done = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        state_d  = StCalc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_adma_dm_axi_ar.sv
// Directed bench for adma_dm_axi_ar: a default instance and a 16-beat-capped instance,
// with a negedge monitor logging every AR and record handshake.
module tb_adma_dm_axi_ar;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [1:0]  cmd_chn_id;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic        cmd_vld;
    logic        atx_rdy;
    logic        m_arready;
    logic [4:0]  atx_id [0:3];

    logic        cmd_rdy_a, cmd_done_a, atx_vld_a, m_arvalid_a;
    logic [1:0]  atx_chn_a;
    logic [4:0]  atx_arid_a, m_arid_a;
    logic [7:0]  atx_arlen_a, m_arlen_a;
    logic [31:0] m_araddr_a;
    logic [2:0]  m_arsize_a;
    logic [1:0]  m_arburst_a;

    logic        cmd_rdy_b, cmd_done_b, atx_vld_b, m_arvalid_b;
    logic [1:0]  atx_chn_b;
    logic [4:0]  atx_arid_b, m_arid_b;
    logic [7:0]  atx_arlen_b, m_arlen_b;
    logic [31:0] m_araddr_b;
    logic [2:0]  m_arsize_b;
    logic [1:0]  m_arburst_b;

    logic        cmd_rdy, cmd_done, atx_vld, m_arvalid;
    logic [1:0]  atx_chn;
    logic [4:0]  atx_arid, m_arid;
    logic [7:0]  atx_arlen, m_arlen;
    logic [31:0] m_araddr;

    assign cmd_rdy   = sel ? cmd_rdy_b   : cmd_rdy_a;
    assign cmd_done  = sel ? cmd_done_b  : cmd_done_a;
    assign atx_vld   = sel ? atx_vld_b   : atx_vld_a;
    assign m_arvalid = sel ? m_arvalid_b : m_arvalid_a;
    assign atx_chn   = sel ? atx_chn_b   : atx_chn_a;
    assign atx_arid  = sel ? atx_arid_b  : atx_arid_a;
    assign atx_arlen = sel ? atx_arlen_b : atx_arlen_a;
    assign m_arid    = sel ? m_arid_b    : m_arid_a;
    assign m_arlen   = sel ? m_arlen_b   : m_arlen_a;
    assign m_araddr  = sel ? m_araddr_b  : m_araddr_a;

    adma_dm_axi_ar u_dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_chn_id  (cmd_chn_id),
        .cmd_addr    (cmd_addr),
        .cmd_beats   (cmd_beats),
        .cmd_vld     (cmd_vld & ~sel),
        .cmd_rdy     (cmd_rdy_a),
        .cmd_done    (cmd_done_a),
        .atx_id      (atx_id),
        .atx_chn_id  (atx_chn_a),
        .atx_arid    (atx_arid_a),
        .atx_arlen   (atx_arlen_a),
        .atx_vld     (atx_vld_a),
        .atx_rdy     (atx_rdy),
        .m_arid_o    (m_arid_a),
        .m_araddr_o  (m_araddr_a),
        .m_arlen_o   (m_arlen_a),
        .m_arsize_o  (m_arsize_a),
        .m_arburst_o (m_arburst_a),
        .m_arvalid_o (m_arvalid_a),
        .m_arready_i (m_arready)
    );

    adma_dm_axi_ar #(.ATX_MAX_BEATS(16)) u_dut16 (
        .clk         (clk),
        .rst         (rst),
        .cmd_chn_id  (cmd_chn_id),
        .cmd_addr    (cmd_addr),
        .cmd_beats   (cmd_beats),
        .cmd_vld     (cmd_vld & sel),
        .cmd_rdy     (cmd_rdy_b),
        .cmd_done    (cmd_done_b),
        .atx_id      (atx_id),
        .atx_chn_id  (atx_chn_b),
        .atx_arid    (atx_arid_b),
        .atx_arlen   (atx_arlen_b),
        .atx_vld     (atx_vld_b),
        .atx_rdy     (atx_rdy),
        .m_arid_o    (m_arid_b),
        .m_araddr_o  (m_araddr_b),
        .m_arlen_o   (m_arlen_b),
        .m_arsize_o  (m_arsize_b),
        .m_arburst_o (m_arburst_b),
        .m_arvalid_o (m_arvalid_b),
        .m_arready_i (m_arready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int hs_cyc   = -1;
    int first_ar = -1;
    int done_cnt = 0;

    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    logic [4:0]  ar_id_q[$];
    logic [1:0]  atx_chn_q[$];
    logic [4:0]  atx_id_q[$];
    logic [7:0]  atx_len_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_vld && cmd_rdy) hs_cyc = cyc;
        if (m_arvalid && first_ar < 0) first_ar = cyc;
        if (m_arvalid && m_arready) begin
            ar_addr_q.push_back(m_araddr);
            ar_len_q.push_back(m_arlen);
            ar_id_q.push_back(m_arid);
        end
        if (atx_vld && atx_rdy) begin
            atx_chn_q.push_back(atx_chn);
            atx_id_q.push_back(atx_arid);
            atx_len_q.push_back(atx_arlen);
        end
        if (cmd_done) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        ar_addr_q.delete();
        ar_len_q.delete();
        ar_id_q.delete();
        atx_chn_q.delete();
        atx_id_q.delete();
        atx_len_q.delete();
        done_cnt = 0;
        first_ar = -1;
        hs_cyc   = -1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the command handshake.
    task automatic send_cmd(input logic [1:0] chn, input logic [31:0] addr,
                            input logic [15:0] beats);
        int n = 0;
        cmd_chn_id = chn;
        cmd_addr   = addr;
        cmd_beats  = beats;
        cmd_vld    = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_rdy && n < 50);
        if (!cmd_rdy) check_eq("cmd_accept_timeout", 64'(cmd_rdy), 64'd1);
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq(tag, 64'(done_cnt - start), 64'd1);
    endtask

    task automatic check_burst(input string tag, input int i, input logic [31:0] addr,
                               input logic [7:0] len, input logic [4:0] id,
                               input logic [1:0] chn);
        check_eq($sformatf("%s_araddr%0d", tag, i),
                 (i < ar_addr_q.size()) ? 64'(ar_addr_q[i]) : '1, 64'(addr));
        check_eq($sformatf("%s_arlen%0d", tag, i),
                 (i < ar_len_q.size()) ? 64'(ar_len_q[i]) : '1, 64'(len));
        check_eq($sformatf("%s_arid%0d", tag, i),
                 (i < ar_id_q.size()) ? 64'(ar_id_q[i]) : '1, 64'(id));
        check_eq($sformatf("%s_atxlen%0d", tag, i),
                 (i < atx_len_q.size()) ? 64'(atx_len_q[i]) : '1, 64'(len));
        check_eq($sformatf("%s_atxid%0d", tag, i),
                 (i < atx_id_q.size()) ? 64'(atx_id_q[i]) : '1, 64'(id));
        check_eq($sformatf("%s_atxchn%0d", tag, i),
                 (i < atx_chn_q.size()) ? 64'(atx_chn_q[i]) : '1, 64'(chn));
    endtask

    initial begin
        rst        = 1'b1;
        sel        = 1'b0;
        cmd_chn_id = '0;
        cmd_addr   = '0;
        cmd_beats  = '0;
        cmd_vld    = 1'b0;
        atx_rdy    = 1'b1;
        m_arready  = 1'b1;
        atx_id[0]  = 5'd3;
        atx_id[1]  = 5'd9;
        atx_id[2]  = 5'd5;
        atx_id[3]  = 5'd17;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_cmd_rdy", 64'(cmd_rdy), 64'd1);
        check_eq("rst_cmd_done", 64'(cmd_done), 64'd0);
        check_eq("rst_arvalid", 64'(m_arvalid), 64'd0);
        check_eq("rst_atx_vld", 64'(atx_vld), 64'd0);
        check_eq("rst_araddr", 64'(m_araddr), 64'd0);
        check_eq("rst_arid", 64'(m_arid), 64'd0);
        check_eq("rst_arsize", 64'(m_arsize_a), 64'd5);
        check_eq("rst_arburst", 64'(m_arburst_a), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single short burst, plus first-AR latency
        clear_log();
        send_cmd(2'd2, 32'h1000, 16'd8);
        wait_done("t1_done", 40);
        check_eq("t1_ar_cnt", 64'(ar_addr_q.size()), 64'd1);
        check_eq("t1_atx_cnt", 64'(atx_len_q.size()), 64'd1);
        check_burst("t1", 0, 32'h1000, 8'd7, 5'd5, 2'd2);
        check_eq("t1_latency", 64'(first_ar - hs_cyc), 64'd2);
        @(negedge clk);
        check_eq("t1_done_pulse", 64'(cmd_done), 64'd0);
        check_eq("t1_idle_rdy", 64'(cmd_rdy), 64'd1);
        @(posedge clk);
        #1;

        // 4KB split, including a burst starting exactly on a 4KB boundary
        clear_log();
        send_cmd(2'd1, 32'h0F80, 16'd300);
        wait_done("t2_done", 200);
        check_eq("t2_ar_cnt", 64'(ar_addr_q.size()), 64'd4);
        check_eq("t2_atx_cnt", 64'(atx_len_q.size()), 64'd4);
        check_burst("t2", 0, 32'h0F80, 8'd3, 5'd9, 2'd1);
        check_burst("t2", 1, 32'h1000, 8'd127, 5'd9, 2'd1);
        check_burst("t2", 2, 32'h2000, 8'd127, 5'd9, 2'd1);
        check_burst("t2", 3, 32'h3000, 8'd39, 5'd9, 2'd1);

        // Burst-length cap on the 16-beat instance
        sel = 1'b1;
        #1;
        clear_log();
        send_cmd(2'd0, 32'h0000, 16'd40);
        wait_done("t3_done", 100);
        check_eq("t3_ar_cnt", 64'(ar_addr_q.size()), 64'd3);
        check_burst("t3", 0, 32'h0000, 8'd15, 5'd3, 2'd0);
        check_burst("t3", 1, 32'h0200, 8'd15, 5'd3, 2'd0);
        check_burst("t3", 2, 32'h0400, 8'd7, 5'd3, 2'd0);
        sel = 1'b0;
        #1;

        // Independent handshakes: AR first, then record first
        clear_log();
        m_arready = 1'b1;
        atx_rdy   = 1'b0;
        send_cmd(2'd3, 32'h2000, 16'd200);
        repeat (6) @(posedge clk);
        #1;
        check_eq("t4a_ar_cnt", 64'(ar_addr_q.size()), 64'd1);
        check_eq("t4a_atx_cnt", 64'(atx_len_q.size()), 64'd0);
        check_eq("t4a_arvalid", 64'(m_arvalid), 64'd0);
        check_eq("t4a_atx_vld", 64'(atx_vld), 64'd1);
        check_eq("t4a_atx_len", 64'(atx_arlen), 64'd127);
        m_arready = 1'b0;
        atx_rdy   = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("t4b_ar_cnt", 64'(ar_addr_q.size()), 64'd1);
        check_eq("t4b_atx_cnt", 64'(atx_len_q.size()), 64'd2);
        check_eq("t4b_arvalid", 64'(m_arvalid), 64'd1);
        check_eq("t4b_atx_vld", 64'(atx_vld), 64'd0);
        check_eq("t4b_araddr", 64'(m_araddr), 64'h3000);
        check_eq("t4b_arlen", 64'(m_arlen), 64'd71);
        check_eq("t4b_arid", 64'(m_arid), 64'd17);
        check_eq("t4b_done", 64'(done_cnt), 64'd0);
        m_arready = 1'b1;
        wait_done("t4c_done", 40);
        check_eq("t4c_ar_cnt", 64'(ar_addr_q.size()), 64'd2);
        check_burst("t4c", 1, 32'h3000, 8'd71, 5'd17, 2'd3);

        // Unaligned start address
        clear_log();
        send_cmd(2'd0, 32'h101F, 16'd4);
        wait_done("t5_done", 40);
        check_burst("t5", 0, 32'h1000, 8'd3, 5'd3, 2'd0);

        // Asynchronous reset while an AR is outstanding
        clear_log();
        m_arready = 1'b0;
        atx_rdy   = 1'b0;
        send_cmd(2'd1, 32'h5000, 16'd16);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t6_arvalid_pre", 64'(m_arvalid), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("t6_arvalid_rst", 64'(m_arvalid), 64'd0);
        check_eq("t6_atx_vld_rst", 64'(atx_vld), 64'd0);
        check_eq("t6_cmd_rdy_rst", 64'(cmd_rdy), 64'd1);
        check_eq("t6_araddr_rst", 64'(m_araddr), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_arready = 1'b1;
        atx_rdy   = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
        send_cmd(2'd2, 32'h6040, 16'd2);
        wait_done("t6_done", 40);
        check_eq("t6_ar_cnt", 64'(ar_addr_q.size()), 64'd1);
        check_burst("t6", 0, 32'h6040, 8'd1, 5'd5, 2'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
